// File: rtl/shift_sequencer.sv
// Command-driven controller for a 4-bit bidirectional shift register: load a word, shift it
// a programmed number of positions with a chosen fill, then capture the result and pulse DONE.
module shift_sequencer #(
  parameter int unsigned W     = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [W-1:0]     CMD_DATA,
  input  logic             CMD_DIR,
  input  logic [AMT_W-1:0] CMD_AMT,
  input  logic [1:0]       CMD_FILL,
  input  logic             SIN,
  input  logic [W-1:0]     Q,
  output logic             S1,
  output logic             S0,
  output logic [W-1:0]     D,
  output logic             DSL,
  output logic             DSR,
  output logic             BUSY,
  output logic [W-1:0]     RESULT,
  output logic             DONE
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapt} state_e;

  state_e           state_q;
  logic [W-1:0]     data_q;
  logic             dir_q;
  logic [1:0]       fill_q;
  logic [AMT_W-1:0] cnt_q;
  logic [W-1:0]     result_q;
  logic             done_q;
  logic             fill_bit;

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q  <= StIdle;
      data_q   <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StCapt);
      unique case (state_q)
        StIdle: begin
          if (CMD_VALID) begin
            data_q  <= CMD_DATA;
            dir_q   <= CMD_DIR;
            fill_q  <= CMD_FILL;
            cnt_q   <= CMD_AMT;
            state_q <= StLoad;
          end
        end
        StLoad: state_q <= (cnt_q != '0) ? StShift : StCapt;
        StShift: begin
          cnt_q <= cnt_q - AMT_W'(1);
          // Leaving on count 1 makes the number of shift edges equal the programmed amount.
          if (cnt_q == AMT_W'(1)) state_q <= StCapt;
        end
        StCapt: begin
          result_q <= Q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Rotate feeds back the bit about to fall off the far end of the register.
  always_comb begin
    fill_bit = 1'b0;
    unique case (fill_q)
      2'b00: fill_bit = 1'b0;
      2'b01: fill_bit = 1'b1;
      2'b10: fill_bit = dir_q ? Q[W-1] : Q[0];
      2'b11: fill_bit = SIN;
      default: fill_bit = 1'b0;
    endcase
  end

  always_comb begin
    S1 = 1'b0;
    S0 = 1'b0;
    unique case (state_q)
      StIdle:  {S1, S0} = 2'b00;
      StLoad:  {S1, S0} = 2'b11;
      StShift: {S1, S0} = dir_q ? 2'b01 : 2'b10;
      StCapt:  {S1, S0} = 2'b00;
      default: {S1, S0} = 2'b00;
    endcase
  end

  assign DSL       = (state_q == StShift) ? fill_bit : 1'b0;
  assign DSR       = DSL;
  assign D         = data_q;
  assign BUSY      = (state_q != StIdle);
  assign CMD_READY = (state_q == StIdle);
  assign RESULT    = result_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: drives directed commands into the controller wired to a
// behavioural 4-bit shift register and checks results and timing through a scoreboard.
module tb_shift_sequencer;

  logic       CP = 1'b0;
  logic       CR = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [3:0] CMD_DATA = '0;
  logic       CMD_DIR = 1'b0;
  logic [2:0] CMD_AMT = '0;
  logic [1:0] CMD_FILL = '0;
  logic       SIN = 1'b0;
  logic [3:0] Q;
  logic       S1, S0;
  logic [3:0] D;
  logic       DSL, DSR, BUSY, DONE;
  logic [3:0] RESULT;

  int asserts = 0;
  int fails = 0;
  int cycle = 0;
  int shift_cnt = 0;

  typedef struct {
    logic [3:0] res;
    int         due;
    int         shifts0;
    int         amt;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.W(4), .AMT_W(3)) dut (
    .CP(CP), .CR(CR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
    .CMD_DIR(CMD_DIR), .CMD_AMT(CMD_AMT), .CMD_FILL(CMD_FILL), .SIN(SIN), .Q(Q),
    .S1(S1), .S0(S0), .D(D), .DSL(DSL), .DSR(DSR), .BUSY(BUSY), .RESULT(RESULT), .DONE(DONE)
  );

  always #5 CP = ~CP;

  // Attached bidirectional shift register.
  logic [3:0] reg_q;
  assign Q = reg_q;
  always @(posedge CP or negedge CR) begin
    if (!CR) reg_q <= '0;
    else begin
      case ({S1, S0})
        2'b11: reg_q <= D;
        2'b10: reg_q <= {DSL, reg_q[3:1]};
        2'b01: reg_q <= {reg_q[2:0], DSR};
        default: reg_q <= reg_q;
      endcase
    end
  end

  always @(posedge CP) cycle <= cycle + 1;

  // Monitor: counts shift cycles, checks serial pins and retires scoreboard entries on DONE.
  always @(negedge CP) begin
    if (S1 ^ S0) shift_cnt = shift_cnt + 1;
    asserts++;
    assert (DSL === DSR && ((S1 ^ S0) || DSL === 1'b0))
    else begin
      fails++;
      $error("FAIL serial_pins: observed DSL=%b DSR=%b S=%b%b expected equal, 0 outside shift",
             DSL, DSR, S1, S0);
    end
    if (DONE === 1'b1) begin
      asserts++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL unexpected_done: observed DONE=1 at cycle %0d expected no DONE", cycle);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        asserts++;
        assert (RESULT === e.res)
        else begin
          fails++;
          $error("FAIL result: observed %b expected %b", RESULT, e.res);
        end
        asserts++;
        assert (cycle === e.due)
        else begin
          fails++;
          $error("FAIL done_latency: observed edge %0d expected edge %0d", cycle, e.due);
        end
        asserts++;
        assert (shift_cnt - e.shifts0 === e.amt)
        else begin
          fails++;
          $error("FAIL shift_count: observed %0d expected %0d", shift_cnt - e.shifts0, e.amt);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] data, input logic dir, input logic [2:0] amt,
                      input logic [1:0] fill, input logic [3:0] exp, input bit track,
                      input bit hold, output bit done_seen);
    int waited = 0;
    @(negedge CP);
    CMD_VALID = 1'b1;
    CMD_DATA  = data;
    CMD_DIR   = dir;
    CMD_AMT   = amt;
    CMD_FILL  = fill;
    while (CMD_READY !== 1'b1 && waited < 40) begin
      @(negedge CP);
      waited++;
    end
    chk("ready_wait", {7'b0, CMD_READY}, 8'h01);
    done_seen = (DONE === 1'b1);
    @(posedge CP);
    #1;
    if (track) sb.push_back('{exp, cycle + amt + 2, shift_cnt, int'(amt)});
    if (!hold) CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge CP);
      #1;
      n++;
    end while ((sb.size() != 0 || BUSY !== 1'b0) && n < 60);
    asserts++;
    assert (sb.size() == 0 && BUSY === 1'b0)
    else begin
      fails++;
      $error("FAIL completion_timeout: observed pending=%0d BUSY=%b expected 0/0", sb.size(), BUSY);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ds;
    // Reset state.
    #12;
    chk("rst_mode", {6'b0, S1, S0}, 8'h00);
    chk("rst_busy_ready", {6'b0, BUSY, CMD_READY}, 8'h01);
    chk("rst_done_result", {3'b0, DONE, RESULT}, 8'h00);
    chk("rst_d_serial", {2'b0, DSL, DSR, D}, 8'h00);
    @(negedge CP);
    CR = 1'b1;

    // Basic shift toward Q[0] with zero fill.
    send(4'b1011, 1'b0, 3'd2, 2'b00, 4'b0010, 1'b1, 1'b0, ds);
    wait_done();

    // Reset during the second shift cycle: command is lost, no DONE.
    send(4'b1011, 1'b0, 3'd3, 2'b00, 4'b0000, 1'b0, 1'b0, ds);
    repeat (2) @(posedge CP);
    @(negedge CP);
    chk("pre_rst_shifting", {6'b0, S1, S0}, 8'h02);
    CR = 1'b0;
    #1;
    chk("midrst_mode", {6'b0, S1, S0}, 8'h00);
    chk("midrst_busy_ready", {6'b0, BUSY, CMD_READY}, 8'h01);
    chk("midrst_done_result", {3'b0, DONE, RESULT}, 8'h00);
    @(negedge CP);
    CR = 1'b1;
    repeat (6) @(negedge CP);
    chk("post_rst_quiet", {3'b0, DONE, RESULT}, 8'h00);

    // Rotate both directions.
    send(4'b1001, 1'b0, 3'd1, 2'b10, 4'b1100, 1'b1, 1'b0, ds);
    wait_done();
    send(4'b1001, 1'b1, 3'd1, 2'b10, 4'b0011, 1'b1, 1'b0, ds);
    wait_done();

    // One-fill toward Q[W-1], including an amount beyond the register width.
    send(4'b0000, 1'b1, 3'd3, 2'b01, 4'b0111, 1'b1, 1'b0, ds);
    wait_done();
    send(4'b0000, 1'b1, 3'd7, 2'b01, 4'b1111, 1'b1, 1'b0, ds);
    wait_done();

    // Zero amount: load then capture directly.
    send(4'b1010, 1'b0, 3'd0, 2'b00, 4'b1010, 1'b1, 1'b0, ds);
    wait_done();

    // Back-to-back with CMD_VALID held: second accept lands in the first DONE cycle.
    send(4'b0110, 1'b0, 3'd2, 2'b00, 4'b0001, 1'b1, 1'b1, ds);
    send(4'b0110, 1'b1, 3'd1, 2'b01, 4'b1101, 1'b1, 1'b0, ds);
    chk("b2b_accept_in_done", {7'b0, ds}, 8'h01);
    wait_done();

    // Requests while busy are ignored.
    send(4'b1111, 1'b0, 3'd4, 2'b00, 4'b0000, 1'b1, 1'b0, ds);
    @(negedge CP);
    CMD_VALID = 1'b1;
    CMD_DATA  = 4'b0101;
    CMD_AMT   = 3'd0;
    repeat (2) @(negedge CP);
    CMD_VALID = 1'b0;
    wait_done();
    repeat (4) @(negedge CP);
    chk("busy_ignore_result", {4'b0, RESULT}, 8'h00);

    // External serial fill: SIN 1,0,1 toward Q[W-1] from 0000.
    send(4'b0000, 1'b1, 3'd3, 2'b11, 4'b0101, 1'b1, 1'b0, ds);
    SIN = 1'b1;
    repeat (2) @(posedge CP);
    #1 SIN = 1'b0;
    @(posedge CP);
    #1 SIN = 1'b1;
    wait_done();
    SIN = 1'b0;

    repeat (3) @(negedge CP);
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller for the 4-bit bidirectional shift register (mode pins S1/S0, parallel D, serial DSL/DSR, output Q). It accepts one command per handshake. For each command it loads a parallel word, shifts the word a programmed number of positions in a chosen direction with a chosen fill source, then captures the register contents and pulses DONE. It sits between a host-side command source and one shift register instance, and it owns that register's S1, S0, D, DSL and DSR pins.

Parameters:
W, 4, shift register width; must match the attached register.
AMT_W, 3, width of the shift-count field; shift amounts 0 to 2^AMT_W-1.

Ports:
CP  input  1  clock; all state changes on rising edge.
CR  input  1  asynchronous, active-low reset.
CMD_VALID  input  1  command present.
CMD_READY  output  1  controller can accept a command.
CMD_DATA  input  W  word to parallel-load.
CMD_DIR  input  1  0 = shift toward Q[0] (mode 10); 1 = shift toward Q[W-1] (mode 01).
CMD_AMT  input  AMT_W  number of shift cycles.
CMD_FILL  input  2  serial fill source: 00 zero, 01 one, 10 rotate, 11 external SIN.
SIN  input  1  external serial bit, sampled combinationally in each shift cycle when FILL=11.
Q  input  W  register output, fed back from the attached register.
S1  output  1  register mode bit 1.
S0  output  1  register mode bit 0.
D  output  W  register parallel data.
DSL  output  1  serial fill bit.
DSR  output  1  serial fill bit; always equal to DSL.
BUSY  output  1  high in any state other than IDLE.
RESULT  output  W  register contents captured at the end of a command.
DONE  output  1  one-cycle pulse when RESULT is updated.

Behaviour:
- Register mode encoding: 11 load D; 10 shift toward Q[0], with the serial bit entering Q[W-1]; 01 shift toward Q[W-1], with the serial bit entering Q[0]; 00 hold. DSL and DSR are both driven with the fill bit, so the fill is correct whichever serial pin the register uses.
- States:
  - IDLE: S=00, CMD_READY=1. A command is accepted on the edge where CMD_VALID=1 and CMD_READY=1. At that edge, DATA/DIR/AMT/FILL are latched into internal registers, the counter is set to AMT, and the state goes to LOAD.
  - LOAD (1 cycle): S=11, D=latched data. Goes to SHIFT if AMT != 0, otherwise to CAPT.
  - SHIFT: S = 10 when DIR=0, 01 when DIR=1. Counter decrements each edge. When the counter reaches 1 at an edge, the state goes to CAPT. Exactly AMT shift edges occur.
  - CAPT (1 cycle): S=00. At the edge, RESULT<=Q, DONE<=1 and the state goes to IDLE.
- Fill bit in SHIFT:
  - FILL 00: 0.
  - FILL 01: 1.
  - FILL 10 (rotate): Q[0] when DIR=0, Q[W-1] when DIR=1.
  - FILL 11: SIN.
- Outside SHIFT, DSL=DSR=0. D is driven with the latched data in all states; only its LOAD value matters.
- Latency: with acceptance at edge 0, DONE is high during the cycle after edge AMT+2. CMD_READY is high in that same cycle, so back-to-back commands are allowed: a new accept can coincide with DONE high.
- DONE is high for exactly one cycle per command. RESULT holds its value until the next CAPT.
- CMD_* inputs are ignored while BUSY. A command cannot be aborted.
- AMT >= W with zero, one or external fill is legal; the register simply fills completely.
- Reset (CR=0, asynchronous, at any time including mid-command): state IDLE, S1=S0=0, DSL=DSR=0, D=0, RESULT=0, DONE=0, BUSY=0, CMD_READY=1, counter=0. The command in flight is lost and no DONE is produced for it.
- S1, S0, DSL, DSR, BUSY and CMD_READY are decoded from state and latched fields, with no extra latency. DONE and RESULT are registered.

Test Plan:
- Reset mid-SHIFT: drive CR low for 1 cycle during the second shift -> S=00, BUSY=0, DONE stays 0, RESULT=0; the next command completes normally.
- DATA=1011, DIR=0, AMT=2, FILL=00 -> register goes 1011, 0101, 0010; RESULT=0010; DONE high in the cycle after edge 4.
- DATA=1001, DIR=0, AMT=1, FILL=10 -> RESULT=1100. DATA=1001, DIR=1, AMT=1, FILL=10 -> RESULT=0011.
- DATA=0000, DIR=1, AMT=3, FILL=01 -> register goes 0001, 0011, 0111; RESULT=0111. Same command with AMT=7 -> RESULT=1111.
- DATA=1010, AMT=0 -> no S=10 or 01 cycle occurs; RESULT=1010; DONE in the cycle after edge 2.
- Back-to-back: CMD_VALID held high with two commands -> the second is accepted in the DONE cycle of the first; CMD_VALID pulses while BUSY are ignored; FILL=11 with SIN=1,0,1 over 3 shifts, DIR=1, from 0000 -> RESULT=0101.
